// File: rtl/store_trace_monitor.sv
// ---------------------------------------------------------------------------
// store_trace_monitor
//   Passive observer of a single-cycle core's store traffic. Each cycle with
//   MemWrite high, the store (PC, DataAdr, WriteData) is captured into a
//   first-word-fall-through trace FIFO that a consumer drains through pop.
//   A small RUN/PASS/FAIL checker watches for the program's terminating store
//   to CHECK_ADDR, or gives up after TIMEOUT cycles.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   MemWrite            store strobe
//   DataAdr, WriteData  store address / data
//   PC                  PC of the storing instruction
//   pop                 consume the FIFO head on this edge
//   head_valid          FIFO non-empty; head_pc/head_addr/head_data valid
//   count, full         occupancy and full flag
//   overflow            sticky: a store was dropped because the FIFO was full
//   misaligned          sticky: a store address had DataAdr[1:0] != 0
//   store_count         stores observed, saturating at 16'hFFFF
//   done, pass          checker reached a terminal state / that state is PASS
// ---------------------------------------------------------------------------
module store_trace_monitor #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] CHECK_ADDR = 32'd100,
  parameter logic [31:0] CHECK_DATA = 32'd7,
  parameter int          TIMEOUT    = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  input  logic [31:0]              PC,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_addr,
  output logic [31:0]              head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     misaligned,
  output logic [15:0]              store_count,
  output logic                     done,
  output logic                     pass
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  // The transition fires on the edge where the counter would reach TIMEOUT.
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  // Trace storage: {pc, addr, data}
  logic [95:0]   mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          misaligned_q, misaligned_d;
  logic [15:0]   store_count_q, store_count_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          fifo_full;
  logic          pop_eff;
  logic          push_eff;
  logic [95:0]   head_word;

  always_comb begin
    fifo_full = (count_q == CW'(DEPTH));
    pop_eff   = pop && (count_q != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    push_eff  = MemWrite && (!fifo_full || pop_eff);

    wr_ptr_d      = push_eff ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop_eff  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = count_q + CW'(push_eff) - CW'(pop_eff);
    overflow_d    = overflow_q || (MemWrite && !push_eff);
    misaligned_d  = misaligned_q || (MemWrite && (DataAdr[1:0] != 2'b00));
    store_count_d = store_count_q;
    if (MemWrite && (store_count_q != 16'hFFFF)) begin
      store_count_d = store_count_q + 16'd1;
    end
  end

  // Checker: the terminating store takes priority over a same-edge timeout.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      RUN: begin
        timer_d = timer_q + TW'(1);
        if (MemWrite && (DataAdr == CHECK_ADDR)) begin
          state_d = (WriteData == CHECK_DATA) ? PASS : FAIL;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = FAIL;
        end
      end
      PASS:    state_d = PASS;
      FAIL:    state_d = FAIL;
      default: state_d = FAIL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      store_count_q <= '0;
      state_q       <= RUN;
      timer_q       <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      misaligned_q  <= misaligned_d;
      store_count_q <= store_count_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
    end
  end

  // Storage is not reset; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= {PC, DataAdr, WriteData};
    end
  end

  always_comb begin
    head_valid = (count_q != '0);
    head_word  = head_valid ? mem_q[rd_ptr_q] : 96'd0;
    head_pc    = head_word[95:64];
    head_addr  = head_word[63:32];
    head_data  = head_word[31:0];
  end

  assign count       = count_q;
  assign full        = fifo_full;
  assign overflow    = overflow_q;
  assign misaligned  = misaligned_q;
  assign store_count = store_count_q;
  assign done        = (state_q != RUN);
  assign pass        = (state_q == PASS);

endmodule
